// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types, defaults and helpers for the token ring arbiter
package ring_pkg;

    // PASS: token visiting a slot; GRANT: slot owns the resource; RELEASE: one-cycle gap
    typedef enum logic [1:0] {
        PASS    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } ring_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 16;

    // Upper bound on slot count supported by the onehot helper
    localparam int MAX_SLOTS = 32;

    // One-hot vector with bit pos set; callers truncate to their slot count
    function automatic logic [MAX_SLOTS-1:0] onehot(input int unsigned pos);
        return MAX_SLOTS'(1) << pos;
    endfunction

endpackage

// File: rtl/token_ring_arbiter_if.sv
// rtl/token_ring_arbiter_if.sv - requester/arbiter bundle for the token ring arbiter
// master: requester side (drives enable/req, sees gnt/token_pos/busy/timeout)
// slave : arbiter side
interface token_ring_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int POS_W = $clog2(N_REQ);

    logic             enable;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [POS_W-1:0] token_pos;
    logic             busy;
    logic             timeout;

    modport master (
        output enable, req,
        input  gnt, token_pos, busy, timeout
    );

    modport slave (
        input  enable, req,
        output gnt, token_pos, busy, timeout
    );
endinterface

// File: rtl/ring_hold_timer.sv
// rtl/ring_hold_timer.sv - grant hold counter with terminal flag at MAX_HOLD-1
// Ports: clk, reset (async, active-high), clear (sync zero), inc (count up),
//        terminal (count has reached MAX_HOLD-1)
module ring_hold_timer #(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic terminal
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (clear) begin
            hold_cnt <= '0;
        end else if (inc) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign terminal = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

endmodule

// File: rtl/token_ring_arbiter.sv
// rtl/token_ring_arbiter.sv - round-robin token ring arbiter with bounded grant hold
// Ports: clk, reset (async, active-high), bus (slave modport):
//   enable    - allows token movement and new grants
//   req       - per-slot level request
//   gnt       - registered one-hot grant
//   token_pos - slot currently holding the token
//   busy      - high while a grant is active
//   timeout   - one-cycle pulse when a grant is revoked by the hold limit
module token_ring_arbiter
    import ring_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  reset,
    token_ring_arbiter_if.slave   bus
);
    localparam int POS_W = $clog2(N_REQ);

    ring_state_e      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, pos_wrap;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             timeout_q, timeout_d;
    logic             hold_done;
    logic             in_grant;

    assign in_grant = (state_q == GRANT);

    // Counter sits at zero outside GRANT, so the first grant cycle sees count 0
    ring_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_grant),
        .inc      (in_grant),
        .terminal (hold_done)
    );

    assign pos_wrap = (pos_q == POS_W'(N_REQ - 1)) ? '0 : pos_q + POS_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PASS;
            pos_q     <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        case (state_q)
            PASS: begin
                gnt_d = '0;
                if (bus.enable) begin
                    if (bus.req[pos_q]) begin
                        state_d = GRANT;
                        gnt_d   = N_REQ'(onehot(32'(pos_q)));
                    end else begin
                        pos_d = pos_wrap;
                    end
                end
            end
            GRANT: begin
                // enable is deliberately not consulted: an active grant is never revoked by it.
                // A request drop wins over the hold limit, so no timeout is flagged then.
                if (!bus.req[pos_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end else if (hold_done) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: begin
                // Always move on, so the releasing slot cannot be re-granted immediately
                gnt_d   = '0;
                pos_d   = pos_wrap;
                state_d = PASS;
            end
            default: begin
                state_d = PASS;
                gnt_d   = '0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.token_pos = pos_q;
    assign bus.busy      = in_grant;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_token_ring_arbiter.sv
// tb/tb_token_ring_arbiter.sv - directed self-checking bench for token_ring_arbiter
module tb_token_ring_arbiter;
    localparam int N  = 4;
    localparam int MH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    token_ring_arbiter_if #(.N_REQ(N)) bus ();

    token_ring_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_reset(input logic [N-1:0] r, input logic en);
        reset      = 1'b1;
        bus.req    = r;
        bus.enable = en;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_g;
        int           slot;

        bus.enable = 1'b0;
        bus.req    = '0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt",     32'(bus.gnt),       32'h0);
        chk("rst_pos",     32'(bus.token_pos), 32'h0);
        chk("rst_busy",    32'(bus.busy),      32'h0);
        chk("rst_timeout", 32'(bus.timeout),   32'h0);

        // Reset in the middle of a grant to slot 1
        bus.enable = 1'b1;
        bus.req    = 4'b0010;
        reset      = 1'b0;
        @(negedge clk);
        chk("rg_pos1", 32'(bus.token_pos), 32'd1);
        chk("rg_gnt0", 32'(bus.gnt),       32'h0);
        @(negedge clk);
        chk("rg_gnt",  32'(bus.gnt),  32'h2);
        chk("rg_busy", 32'(bus.busy), 32'h1);
        @(negedge clk);
        chk("rg_gnt_hold", 32'(bus.gnt), 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("rg_async_gnt",     32'(bus.gnt),       32'h0);
        chk("rg_async_pos",     32'(bus.token_pos), 32'h0);
        chk("rg_async_busy",    32'(bus.busy),      32'h0);
        chk("rg_async_timeout", 32'(bus.timeout),   32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("rg_resume_pos0", 32'(bus.token_pos), 32'd0);
        @(negedge clk);
        chk("rg_resume_pos1", 32'(bus.token_pos), 32'd1);
        @(negedge clk);
        chk("rg_regrant", 32'(bus.gnt), 32'h2);

        // Only req[2]: token walks 0,1,2 then grants
        start_reset(4'b0100, 1'b1);
        @(negedge clk);
        chk("walk_pos1", 32'(bus.token_pos), 32'd1);
        @(negedge clk);
        chk("walk_pos2", 32'(bus.token_pos), 32'd2);
        chk("walk_nogt", 32'(bus.gnt),       32'h0);
        @(negedge clk);
        chk("walk_gnt",  32'(bus.gnt),       32'h4);
        chk("walk_busy", 32'(bus.busy),      32'h1);
        chk("walk_pos",  32'(bus.token_pos), 32'd2);
        bus.req = '0;
        @(negedge clk);
        chk("walk_rel_gnt",  32'(bus.gnt),     32'h0);
        chk("walk_rel_to",   32'(bus.timeout), 32'h0);
        chk("walk_rel_busy", 32'(bus.busy),    32'h0);
        @(negedge clk);
        chk("walk_next_pos", 32'(bus.token_pos), 32'd3);

        // Hold limit: req[0] stays high
        start_reset(4'b0001, 1'b1);
        for (int i = 0; i < MH; i++) begin
            @(negedge clk);
            chk("to_gnt_high", 32'(bus.gnt),     32'h1);
            chk("to_no_pulse", 32'(bus.timeout), 32'h0);
        end
        @(negedge clk);
        chk("to_gnt_drop", 32'(bus.gnt),     32'h0);
        chk("to_pulse",    32'(bus.timeout), 32'h1);
        chk("to_busy",     32'(bus.busy),    32'h0);
        @(negedge clk);
        chk("to_pos1",       32'(bus.token_pos), 32'd1);
        chk("to_pulse_once", 32'(bus.timeout),   32'h0);
        @(negedge clk);
        chk("to_pos2", 32'(bus.token_pos), 32'd2);
        @(negedge clk);
        chk("to_pos3", 32'(bus.token_pos), 32'd3);
        @(negedge clk);
        chk("to_pos0",  32'(bus.token_pos), 32'd0);
        chk("to_nogt0", 32'(bus.gnt),       32'h0);
        @(negedge clk);
        chk("to_regrant", 32'(bus.gnt), 32'h1);

        // All requesting, each holds 3 cycles then re-raises a cycle after release
        start_reset(4'b1111, 1'b1);
        for (int s = 0; s < 5; s++) begin
            slot  = s % N;
            exp_g = N'(1) << slot;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("rr_gnt",     32'(bus.gnt),     32'(exp_g));
                chk("rr_timeout", 32'(bus.timeout), 32'h0);
                if (c == 2) bus.req[slot] = 1'b0;
            end
            @(negedge clk);
            chk("rr_rel_gnt", 32'(bus.gnt),     32'h0);
            chk("rr_rel_to",  32'(bus.timeout), 32'h0);
            bus.req[slot] = 1'b1;
            @(negedge clk);
            chk("rr_pos",      32'(bus.token_pos), 32'((slot + 1) % N));
            chk("rr_pass_gnt", 32'(bus.gnt),       32'h0);
        end

        // enable low parks the token and does not disturb an active grant
        start_reset(4'b0000, 1'b1);
        @(negedge clk);
        chk("en_pos1", 32'(bus.token_pos), 32'd1);
        bus.enable = 1'b0;
        bus.req    = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en_park_pos", 32'(bus.token_pos), 32'd1);
            chk("en_park_gnt", 32'(bus.gnt),       32'h0);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        chk("en_gnt", 32'(bus.gnt), 32'h2);
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_gnt_kept",  32'(bus.gnt),  32'h2);
            chk("en_busy_kept", 32'(bus.busy), 32'h1);
        end
        bus.req = '0;
        @(negedge clk);
        chk("en_rel_gnt", 32'(bus.gnt),     32'h0);
        chk("en_rel_to",  32'(bus.timeout), 32'h0);
        @(negedge clk);
        chk("en_rel_pos",  32'(bus.token_pos), 32'd2);
        chk("en_rel_busy", 32'(bus.busy),      32'h0);
        @(negedge clk);
        chk("en_park_pos2", 32'(bus.token_pos), 32'd2);

        // Request drop coincides with the final hold cycle
        start_reset(4'b0001, 1'b1);
        for (int i = 0; i < MH; i++) begin
            @(negedge clk);
            chk("sim_gnt", 32'(bus.gnt), 32'h1);
            if (i == MH - 1) bus.req = '0;
        end
        @(negedge clk);
        chk("sim_gnt_drop", 32'(bus.gnt),     32'h0);
        chk("sim_no_to",    32'(bus.timeout), 32'h0);
        chk("sim_busy",     32'(bus.busy),    32'h0);
        @(negedge clk);
        chk("sim_pos1", 32'(bus.token_pos), 32'd1);
        chk("sim_to0",  32'(bus.timeout),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
